// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, WB control bit indices and word-index helper for mem_stage
package mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;
  localparam int RD_W_DEF   = 5;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Byte address to word index: drop the byte offset, wrap modulo depth.
  function automatic int unsigned word_index(input logic [31:0] addr, input int unsigned depth);
    return (addr >> 2) & (depth - 1);
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// rtl/mem_stage_data_mem.sv - word RAM, synchronous write, registered read that holds when not reading
// Optional MEMSTAGE_RST_CLEAR_EN: reset also zeroes every word.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef MEMSTAGE_RST_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= wdata;
    end
  end
`else
  // No reset on the array so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[idx] <= wdata;
  end
`endif

  // Nonblocking read of mem gives read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (!rst) rdata <= '0;
    else if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: branch select, data memory access, MEM/WB register
// Optional MEMSTAGE_RST_CLEAR_EN: reset clears data memory contents.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_latch,
  input  logic              ex_mem_zero,
  input  logic              memWrite,
  input  logic              memRead,
  input  logic [1:0]        ex_mem_wb,
  input  logic [RD_W-1:0]   ex_mux,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  output logic              PCSrc,
  output logic              regWrite,
  output logic              memReg,
  output logic [RD_W-1:0]   ex_mux_out,
  output logic [DATA_W-1:0] readData,
  output logic [DATA_W-1:0] address_out
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] idx;

  assign idx   = IDX_W'(word_index(32'(address), DEPTH));
  assign PCSrc = ex_mem_latch & ex_mem_zero & rst;

  data_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_data_mem (
    .clk   (clk),
    .rst   (rst),
    .wr_en (memWrite),
    .rd_en (memRead),
    .idx   (idx),
    .wdata (writeData),
    .rdata (readData)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      regWrite    <= 1'b0;
      memReg      <= 1'b0;
      ex_mux_out  <= '0;
      address_out <= '0;
    end else begin
      regWrite    <= ex_mem_wb[WB_REGWRITE];
      memReg      <= ex_mem_wb[WB_MEMTOREG];
      ex_mux_out  <= ex_mux;
      address_out <= address;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int RD_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_mem_latch, ex_mem_zero, memWrite, memRead;
  logic [1:0]        ex_mem_wb;
  logic [RD_W-1:0]   ex_mux;
  logic [DATA_W-1:0] address, writeData;
  logic              PCSrc, regWrite, memReg;
  logic [RD_W-1:0]   ex_mux_out;
  logic [DATA_W-1:0] readData, address_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_mem_latch (ex_mem_latch),
    .ex_mem_zero  (ex_mem_zero),
    .memWrite     (memWrite),
    .memRead      (memRead),
    .ex_mem_wb    (ex_mem_wb),
    .ex_mux       (ex_mux),
    .address      (address),
    .writeData    (writeData),
    .PCSrc        (PCSrc),
    .regWrite     (regWrite),
    .memReg       (memReg),
    .ex_mux_out   (ex_mux_out),
    .readData     (readData),
    .address_out  (address_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_mem_latch = 0; ex_mem_zero = 0; memWrite = 0; memRead = 0;
    ex_mem_wb = 2'b00;
  endtask

  task automatic test_reset();
    rst = 0; ex_mem_latch = 1; ex_mem_zero = 1; memWrite = 1; memRead = 1;
    ex_mem_wb = 2'b11; ex_mux = 5'd7; address = 32'h10; writeData = 32'h5555;
    #1;
    checks++;
    if (PCSrc !== 1'b0) begin errors++; $display("FAIL reset_pcsrc got=%b exp=0", PCSrc); end
    step();
    checks++;
    if ({regWrite, memReg} !== 2'b00) begin
      errors++; $display("FAIL reset_wb got=%b exp=00", {regWrite, memReg});
    end
    checks++;
    if (ex_mux_out !== '0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", ex_mux_out); end
    checks++;
    if (address_out !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", address_out); end
    checks++;
    if (readData !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", readData); end
    rst = 1; idle();
  endtask

  task automatic test_branch();
    ex_mem_latch = 1; ex_mem_zero = 1; #1;
    checks++;
    if (PCSrc !== 1'b1) begin errors++; $display("FAIL branch_taken got=%b exp=1", PCSrc); end
    ex_mem_latch = 0; #1;
    checks++;
    if (PCSrc !== 1'b0) begin errors++; $display("FAIL branch_nolatch got=%b exp=0", PCSrc); end
    ex_mem_latch = 1; ex_mem_zero = 0; #1;
    checks++;
    if (PCSrc !== 1'b0) begin errors++; $display("FAIL branch_nozero got=%b exp=0", PCSrc); end
    idle();
  endtask

  task automatic test_store_load();
    memWrite = 1; address = 32'h0; writeData = 32'hABCDEF12; ex_mux = 5'd2;
    step();
    checks++;
    if (ex_mux_out !== 5'd2) begin errors++; $display("FAIL st_rd got=%0d exp=2", ex_mux_out); end
    checks++;
    if (address_out !== 32'h0) begin errors++; $display("FAIL st_addr got=%h exp=0", address_out); end
    memWrite = 0; memRead = 1; ex_mux = 5'd1;
    step();
    checks++;
    if (readData !== 32'hABCDEF12) begin
      errors++; $display("FAIL ld_data got=%h exp=abcdef12", readData);
    end
    checks++;
    if (ex_mux_out !== 5'd1) begin errors++; $display("FAIL ld_rd got=%0d exp=1", ex_mux_out); end
    idle();
  endtask

  task automatic test_hold_wrap();
    address = 32'h44; step();
    checks++;
    if (readData !== 32'hABCDEF12) begin
      errors++; $display("FAIL hold got=%h exp=abcdef12", readData);
    end
    checks++;
    if (address_out !== 32'h44) begin errors++; $display("FAIL hold_addr got=%h exp=44", address_out); end
    memWrite = 1; address = DEPTH * 4; writeData = 32'h1; step();
    memWrite = 0; memRead = 1; address = 32'h0; step();
    checks++;
    if (readData !== 32'h1) begin errors++; $display("FAIL wrap_hi got=%h exp=1", readData); end
    address = 32'h3; writeData = 32'hDEAD; step();
    checks++;
    if (readData !== 32'h1) begin errors++; $display("FAIL wrap_lowbits got=%h exp=1", readData); end
    memRead = 0; memWrite = 1; address = 32'h3FC; writeData = 32'h77; step();
    memWrite = 0; memRead = 1; address = 32'h7FC; step();
    checks++;
    if (readData !== 32'h77) begin errors++; $display("FAIL wrap_top got=%h exp=77", readData); end
    idle();
  endtask

  task automatic test_same_word();
    memWrite = 1; address = 32'h4; writeData = 32'hA; step();
    memRead = 1; writeData = 32'hB; step();
    checks++;
    if (readData !== 32'hA) begin errors++; $display("FAIL rbw_old got=%h exp=a", readData); end
    memWrite = 0; step();
    checks++;
    if (readData !== 32'hB) begin errors++; $display("FAIL rbw_new got=%h exp=b", readData); end
    idle();
  endtask

  task automatic test_wb();
    ex_mem_wb = 2'b10; step();
    checks++;
    if ({regWrite, memReg} !== 2'b10) begin
      errors++; $display("FAIL wb_10 got=%b exp=10", {regWrite, memReg});
    end
    ex_mem_wb = 2'b01; step();
    checks++;
    if ({regWrite, memReg} !== 2'b01) begin
      errors++; $display("FAIL wb_01 got=%b exp=01", {regWrite, memReg});
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_after;
    memWrite = 1; address = 32'h40; writeData = 32'h11; step();
    rst = 0; memRead = 1; writeData = 32'h99; ex_mem_wb = 2'b11; step();
    checks++;
    if (readData !== '0) begin errors++; $display("FAIL rstmid_rdata got=%h exp=0", readData); end
    checks++;
    if (regWrite !== 1'b0) begin errors++; $display("FAIL rstmid_wb got=%b exp=0", regWrite); end
    rst = 1; memWrite = 0; ex_mem_wb = 2'b00; step();
`ifdef MEMSTAGE_RST_CLEAR_EN
    exp_after = 32'h0;
`else
    exp_after = 32'h11;
`endif
    checks++;
    if (readData !== exp_after) begin
      errors++; $display("FAIL rstmid_suppress got=%h exp=%h", readData, exp_after);
    end
    checks++;
    if (address_out !== 32'h40) begin errors++; $display("FAIL rstmid_resume got=%h exp=40", address_out); end
    idle();
  endtask

  initial begin
    idle(); rst = 0; ex_mux = '0; address = '0; writeData = '0;
    @(negedge clk);
    test_reset();
    test_branch();
    test_store_load();
    test_hold_wrap();
    test_same_word();
    test_wb();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
